counter_burst_arbiter: RTL and testbench

- Shares one up/down step counter between N_REQ requesters using round-robin arbitration.
- Each requester asks for a burst of 1..16 steps in a fixed direction.
- The block grants one requester at a time, sequences that burst at one step per clock, then signals completion.
- The counter value is held internally and exported; wrap or saturate behaviour is selectable per burst.

---
 rtl/counter_burst_arbiter.sv | 140 ++++++++++++++
 tb/tb_counter_burst_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/counter_burst_arbiter.sv
// Round-robin arbiter sharing one up/down step counter between N_REQ requesters.
// The granted requester gets a 1..16 step burst, with wrap or saturate chosen per burst.
module counter_burst_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_dir,
  input  logic [4*N_REQ-1:0]   req_len,
  input  logic                 sat_en,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 clip
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_ptr, w_sel, w_cand;
  logic             w_found;
  logic             r_dir, r_sat;
  logic [3:0]       r_rem, w_len;
  logic [WIDTH-1:0] r_count, w_count_nxt, w_step;
  logic [N_REQ-1:0] r_gnt, r_done, w_gnt_nxt, w_done_nxt;
  logic             r_busy, r_clip, w_busy_nxt, w_clip_nxt, w_at_bound, w_clip;

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign count = r_count;
  assign busy  = r_busy;
  assign clip  = r_clip;

  // First asserted requester at or above the RR pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
    w_len = req_len[{w_sel, 2'b00} +: 4];
  end

  always_comb begin
    w_at_bound = r_dir ? (r_count == {WIDTH{1'b1}}) : (r_count == {WIDTH{1'b0}});
    w_clip     = w_at_bound && r_sat;
    if (w_clip)
      w_step = r_count;
    else if (r_dir)
      w_step = r_count + WIDTH'(1);
    else
      w_step = r_count - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_clip  <= w_clip_nxt;
    end
  end

  always_comb begin
    case (r_state)
      S_IDLE:  w_state_nxt = w_found ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = (r_rem == 4'd0) ? S_IDLE : S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; done goes to whoever held the grant.
  always_comb begin
    w_count_nxt = r_count;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = '0;
    w_clip_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt  = N_REQ'(1) << w_sel;
          w_busy_nxt = 1'b1;
        end else begin
          w_gnt_nxt  = r_gnt;
        end
      end
      S_RUN: begin
        w_count_nxt = w_step;
        w_clip_nxt  = w_clip;
        if (r_rem == 4'd0) begin
          w_gnt_nxt  = '0;
          w_busy_nxt = 1'b0;
          w_done_nxt = r_gnt;
        end else begin
          w_done_nxt = '0;
        end
      end
      default: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Burst context is captured at grant so input changes mid-burst are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_rem <= 4'd0;
      r_dir <= 1'b0;
      r_sat <= 1'b0;
    end else if (r_state == S_IDLE && w_found) begin
      r_ptr <= (w_sel == IW'(N_REQ - 1)) ? '0 : w_sel + IW'(1);
      r_rem <= w_len;
      r_dir <= req_dir[w_sel];
      r_sat <= sat_en;
    end else if (r_state == S_RUN && r_rem != 4'd0) begin
      r_rem <= r_rem - 4'd1;
    end
  end
endmodule

// File: tb/tb_counter_burst_arbiter.sv
// Directed bench for counter_burst_arbiter: a behavioural model checked every cycle,
// plus literal expectations at the points called out for the shared counter.
module tb_counter_burst_arbiter;
  localparam int W = 8;
  localparam int N = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0, req_dir = '0;
  logic [4*N-1:0] req_len = '0;
  logic         sat_en = 1'b0;
  logic [N-1:0] gnt, done;
  logic [W-1:0] count;
  logic         busy, clip;

  int n_checks = 0;
  int n_pass   = 0;

  counter_burst_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_len(req_len),
    .sat_en(sat_en), .gnt(gnt), .done(done), .count(count), .busy(busy), .clip(clip)
  );

  always #5 clk = ~clk;

  // Model state: the burst is tracked as a number of steps still to apply.
  int m_count = 0, m_left = 0, m_owner = 0, m_ptr = 0;
  bit m_busy = 0, m_dir = 0, m_sat = 0, m_clip = 0;
  logic [N-1:0] m_gnt = '0, m_done = '0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit hits_bound(input int c, input bit up);
    return up ? (c == MAXV) : (c == 0);
  endfunction

  function automatic int next_count(input int c, input bit up, input bit sat);
    if (sat && hits_bound(c, up)) return c;
    return (c + (up ? 1 : MAXV)) % (MAXV + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count <= 0; m_left <= 0; m_owner <= 0; m_ptr <= 0;
      m_busy <= 0; m_clip <= 0; m_gnt <= '0; m_done <= '0;
    end else if (!m_busy) begin
      m_done <= '0;
      m_clip <= 0;
      if (pick(req, m_ptr) >= 0) begin
        m_owner <= pick(req, m_ptr);
        m_left  <= int'(req_len[4*pick(req, m_ptr) +: 4]) + 1;
        m_dir   <= req_dir[pick(req, m_ptr)];
        m_sat   <= sat_en;
        m_gnt   <= N'(1) << pick(req, m_ptr);
        m_busy  <= 1;
        m_ptr   <= (pick(req, m_ptr) + 1) % N;
      end
    end else begin
      m_count <= next_count(m_count, m_dir, m_sat);
      m_clip  <= m_sat && hits_bound(m_count, m_dir);
      m_left  <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 0;
        m_gnt  <= '0;
        m_done <= N'(1) << m_owner;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("count", 32'(count), 32'(m_count));
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("clip", 32'(clip), 32'(m_clip));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("done_vs_busy", 32'((done != '0) && busy), 32'd0);
  end

  // Holds requests until a done pulse; the finished requester's bit is dropped.
  task automatic run_burst(output logic [N-1:0] d, output int clips);
    d = '0;
    clips = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clip) clips++;
      if (done != '0) begin
        d = done;
        req = req & ~done;
        return;
      end
    end
    n_checks++;
    $display("FAIL burst_timeout: no done within 40 cycles, req=%0b", req);
  endtask

  logic [N-1:0] d;
  int clips;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_clip", 32'({done, clip}), 32'd0);
    rst = 1'b0;

    // up len=3 from 0, wrap mode
    req_dir = 2'b01; req_len = 8'h03; sat_en = 1'b0; req = 2'b01;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    run_burst(d, clips);
    chk("t1_done", 32'(d), 32'h1);
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_model_count", 32'(m_count), 32'd4);
    chk("t1_gnt_clear", 32'(gnt), 32'h0);

    // simultaneous requests from reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req_dir = 2'b01; req_len = 8'h10; req = 2'b11;
    run_burst(d, clips);
    chk("t2_done0", 32'(d), 32'h1);
    chk("t2_count1", 32'(count), 32'd1);
    run_burst(d, clips);
    req = 2'b00;
    chk("t2_done1", 32'(d), 32'h2);
    chk("t2_count255", 32'(count), 32'd255);
    req = 2'b11;
    @(negedge clk);
    chk("t2_rr_back", 32'(gnt), 32'h1);
    run_burst(d, clips);
    req = 2'b00;
    chk("t2_wrap_up", 32'(count), 32'd0);

    // reach 254, then saturating up burst
    req_dir = 2'b00; req_len = 8'h01; req = 2'b01;
    run_burst(d, clips);
    chk("t3_254", 32'(count), 32'd254);
    req_dir = 2'b01; req_len = 8'h03; sat_en = 1'b1; req = 2'b01;
    run_burst(d, clips);
    chk("t3_sat_count", 32'(count), 32'd255);
    chk("t3_clips", 32'(clips), 32'd3);
    chk("t3_model_count", 32'(m_count), 32'd255);

    // single-step bounds
    sat_en = 1'b0; req_len = 8'h00; req_dir = 2'b01; req = 2'b01;
    run_burst(d, clips);
    chk("t4_to0", 32'(count), 32'd0);
    req_dir = 2'b00; req = 2'b01;
    run_burst(d, clips);
    chk("t4_wrap_down", 32'(count), 32'd255);
    chk("t4_wrap_clips", 32'(clips), 32'd0);
    req_dir = 2'b01; req = 2'b01;
    run_burst(d, clips);
    sat_en = 1'b1; req_dir = 2'b00; req = 2'b01;
    run_burst(d, clips);
    chk("t4_sat_down", 32'(count), 32'd0);
    chk("t4_sat_clip", 32'(clips), 32'd1);

    // reset mid-burst
    sat_en = 1'b0; req_dir = 2'b01; req_len = 8'h07; req = 2'b01;
    repeat (3) @(negedge clk);
    chk("t5_step2", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t5_abort_count", 32'(count), 32'd0);
    chk("t5_abort_gnt", 32'(gnt), 32'h0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 2'b11;
    @(negedge clk);
    chk("t5_regrant", 32'(gnt), 32'h1);
    run_burst(d, clips);
    req = 2'b00;
    chk("t5_done", 32'(d), 32'h1);
    chk("t5_count", 32'(count), 32'd8);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
